// File: rtl/ones_density_monitor_pkg.sv
// Shared types for the ones-density monitor: FSM states, sample kinds and
// the header fields carried in front of each event timestamp.
package ones_mon_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2,
        RECOVER = 2'd3
    } mon_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } ones_kind_e;

    // Event word is {hdr, ts}; hdr sits in the top three bits.
    typedef struct packed {
        logic       rise;
        ones_kind_e kind;
    } evt_hdr_t;

endpackage

// File: rtl/ones_density_monitor_if.sv
// Valid/ready event stream leaving the monitor: {rise, kind, ts}.
interface ones_density_monitor_if #(
    parameter int TS_W = 16
) ();
    logic              evt_valid;
    logic              evt_ready;
    logic [TS_W+2:0]   evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/ones_density_monitor_evt_fifo.sv
// Two-entry valid/ready FIFO; head is held in a register so rdata is stable
// until popped. A push into a full FIFO is only taken alongside a pop.
module mon_evt_fifo #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] rdata
);
    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         valid_q, valid_d;
    logic         rd, wr;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        rd     = valid_q && ready;
        wr     = push && ((cnt_q != 2'd2) || rd);
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({wr, rd})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = wdata;
                    end else begin
                        head_d = tail_q;
                        tail_d = wdata;
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) head_d = wdata;
                    else               tail_d = wdata;
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    assign full  = (cnt_q == 2'd2);
    assign valid = valid_q;
    assign rdata = head_q;

endmodule

// File: rtl/ones_density_monitor.sv
// Classifies popcount samples against [thr_lo, thr_hi], debounces an alarm,
// logs timestamped rise/fall events and keeps min/max/alarm statistics.
module ones_density_monitor
    import ones_mon_pkg::*;
#(
    parameter int ONES_W    = 8,
    parameter int TRIP_CNT  = 4,
    parameter int CLEAR_CNT = 8,
    parameter int TS_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ones_valid,
    input  logic [ONES_W-1:0]    ones,
    input  logic [ONES_W-1:0]    thr_lo,
    input  logic [ONES_W-1:0]    thr_hi,
    input  logic                 clear,
    output logic                 alarm,
    output logic [1:0]           alarm_kind,
    ones_density_monitor_if.master evt,
    output logic                 evt_ovf,
    output logic [ONES_W-1:0]    min_ones,
    output logic [ONES_W-1:0]    max_ones,
    output logic [TS_W-1:0]      alarm_count
);
    localparam int RUN_MAX = (TRIP_CNT > CLEAR_CNT) ? TRIP_CNT : CLEAR_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] TRIP_R  = RUN_W'(TRIP_CNT);
    localparam logic [RUN_W-1:0] CLEAR_R = RUN_W'(CLEAR_CNT);

    function automatic ones_kind_e classify(input logic [ONES_W-1:0] v,
                                            input logic [ONES_W-1:0] lo,
                                            input logic [ONES_W-1:0] hi);
        if (v < lo) return LOW;
        if (v > hi) return HIGH;
        return NONE;
    endfunction

    function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
        return (v == '1) ? v : v + TS_W'(1);
    endfunction

    mon_state_e          state_q, state_d;
    ones_kind_e          kind_q, kind_d, cls;
    logic [RUN_W-1:0]    run_q, run_d, run_inc;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [TS_W-1:0]     acnt_q, acnt_d;
    logic [ONES_W-1:0]   min_q, min_d, max_q, max_d;
    logic                alarm_q, alarm_d, ovf_q, ovf_d;
    logic [1:0]          akind_q, akind_d;
    logic                push_req, pop, fifo_full;
    evt_hdr_t            push_hdr;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        run_d    = run_q;
        ts_d     = ts_q;
        acnt_d   = acnt_q;
        min_d    = min_q;
        max_d    = max_q;
        ovf_d    = ovf_q;
        push_req = 1'b0;
        push_hdr = '{rise: 1'b0, kind: NONE};
        cls      = classify(ones, thr_lo, thr_hi);
        run_inc  = run_q + RUN_W'(1);
        pop      = evt.evt_valid && evt.evt_ready;

        if (clear) begin
            state_d = NORMAL;
            kind_d  = NONE;
            run_d   = '0;
            acnt_d  = '0;
            min_d   = '1;
            max_d   = '0;
            ovf_d   = 1'b0;
        end else if (ones_valid) begin
            ts_d = ts_q + TS_W'(1);
            if (ones < min_q) min_d = ones;
            if (ones > max_q) max_d = ones;
            unique case (state_q)
                NORMAL: begin
                    if (cls != NONE) begin
                        kind_d = cls;
                        if (TRIP_CNT == 1) begin
                            state_d  = ALARM;
                            push_req = 1'b1;
                            push_hdr = '{rise: 1'b1, kind: cls};
                            acnt_d   = sat_inc(acnt_q);
                        end else begin
                            state_d = PENDING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                PENDING: begin
                    if (cls == NONE) begin
                        state_d = NORMAL;
                        kind_d  = NONE;
                        run_d   = '0;
                    end else if (cls != kind_q) begin
                        kind_d = cls;
                        run_d  = RUN_W'(1);
                    end else if (run_inc == TRIP_R) begin
                        state_d  = ALARM;
                        run_d    = '0;
                        push_req = 1'b1;
                        push_hdr = '{rise: 1'b1, kind: cls};
                        acnt_d   = sat_inc(acnt_q);
                    end else begin
                        run_d = run_inc;
                    end
                end
                ALARM: begin
                    if (cls != NONE) begin
                        kind_d = cls;
                    end else if (CLEAR_CNT == 1) begin
                        state_d  = NORMAL;
                        kind_d   = NONE;
                        push_req = 1'b1;
                        push_hdr = '{rise: 1'b0, kind: kind_q};
                    end else begin
                        state_d = RECOVER;
                        run_d   = RUN_W'(1);
                    end
                end
                RECOVER: begin
                    if (cls != NONE) begin
                        state_d = ALARM;
                        kind_d  = cls;
                        run_d   = '0;
                    end else if (run_inc == CLEAR_R) begin
                        state_d  = NORMAL;
                        kind_d   = NONE;
                        run_d    = '0;
                        push_req = 1'b1;
                        push_hdr = '{rise: 1'b0, kind: kind_q};
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: ;
            endcase
        end

        // A full queue without a same-cycle pop cannot take the new event.
        if (!clear && push_req && fifo_full && !pop) ovf_d = 1'b1;

        alarm_d = (state_d == ALARM) || (state_d == RECOVER);
        akind_d = (state_d == NORMAL) ? 2'd0 : kind_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            kind_q  <= NONE;
            run_q   <= '0;
            ts_q    <= '0;
            acnt_q  <= '0;
            min_q   <= '1;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            alarm_q <= 1'b0;
            akind_q <= 2'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            run_q   <= run_d;
            ts_q    <= ts_d;
            acnt_q  <= acnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            alarm_q <= alarm_d;
            akind_q <= akind_d;
        end
    end

    mon_evt_fifo #(.W(TS_W + 3)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (push_req),
        .wdata ({push_hdr, ts_q}),
        .full  (fifo_full),
        .valid (evt.evt_valid),
        .ready (evt.evt_ready),
        .rdata (evt.evt_data)
    );

    assign alarm       = alarm_q;
    assign alarm_kind  = akind_q;
    assign evt_ovf     = ovf_q;
    assign min_ones    = min_q;
    assign max_ones    = max_q;
    assign alarm_count = acnt_q;

endmodule

// File: doc/ones_density_monitor.md
# ones_density_monitor

Downstream consumer of the popcount stage's `ones` output. Classifies each popcount sample against a programmable band [`thr_lo`, `thr_hi`]. Asserts a debounced alarm after a run of consecutive out-of-band samples and releases it after a run of consecutive in-band samples. Logs rise/fall transitions as timestamped events through a 2-entry valid/ready queue, and keeps running min/max and alarm statistics.

## Interface
- `ONES_W`, 8: width of `ones` and the thresholds.
- `TRIP_CNT`, 4: consecutive out-of-band samples needed to raise the alarm (≥1).
- `CLEAR_CNT`, 8: consecutive in-band samples needed to release the alarm (≥1).
- `TS_W`, 16: width of the timestamp and the alarm counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ones_valid`  in  1  `ones` carries a sample this cycle.
- `ones`  in  ONES_W  popcount sample.
- `thr_lo`, `thr_hi`  in  ONES_W  band limits, inclusive. Quasi-static.
- `clear`  in  1  synchronous soft clear, one-cycle pulse.
- `alarm`  out  1  debounced alarm.
- `alarm_kind`  out  2  latest out-of-band kind: 0 = none, 1 = LOW, 2 = HIGH.
- `evt_valid`  out  1  head of the event queue is valid.
- `evt_ready`  in  1  consumer accepts the head.
- `evt_data`  out  TS_W+3  event word = {rise, kind[1:0], ts[TS_W-1:0]}.
- `evt_ovf`  out  1  sticky flag: an event was dropped because the queue was full.
- `min_ones`, `max_ones`  out  ONES_W  extremes of samples seen since reset or clear.
- `alarm_count`  out  TS_W  number of alarm rises, saturating.

## Operation
- Sample classification, applied only when `ones_valid` = 1:
  - LOW if `ones` < `thr_lo`.
  - Else HIGH if `ones` > `thr_hi`.
  - Else IN.
  - LOW is checked first, so it wins if `thr_lo` > `thr_hi`.
- Timestamp `ts`: free-running count of valid samples; wraps modulo 2^TS_W. The first valid sample after reset has `ts` = 0.
- FSM states are NORMAL, PENDING, ALARM, RECOVER. A run counter `run` counts qualifying samples in PENDING and RECOVER.
  - NORMAL:
    - LOW/HIGH with TRIP_CNT = 1 → ALARM.
    - Other LOW/HIGH → PENDING with `run` = 1; record kind.
  - PENDING:
    - Same kind → `run`+1; when `run` reaches TRIP_CNT → ALARM.
    - Opposite kind → stay in PENDING, `run` = 1, kind updated.
    - IN → NORMAL, `run` = 0.
  - ALARM:
    - LOW/HIGH → stay; `alarm_kind` follows the latest sample.
    - IN with CLEAR_CNT = 1 → NORMAL.
    - Other IN → RECOVER with `run` = 1.
  - RECOVER:
    - IN → `run`+1; when `run` reaches CLEAR_CNT → NORMAL.
    - LOW/HIGH → ALARM, `run` = 0, kind updated.
- `alarm` = 1 in the ALARM and RECOVER states.
- Entry into ALARM from NORMAL or PENDING:
  - Pushes event {1, kind, ts of the tripping sample}.
  - `alarm_count` increments and saturates at all-ones.
- Entry into NORMAL from ALARM or RECOVER pushes event {0, last kind, ts of the releasing sample}.
- `alarm_kind` = 0 in NORMAL. It holds the recorded kind in PENDING, ALARM and RECOVER.
- Event queue: 2 entries, FIFO order.
  - Push into a full queue drops the new event and sets `evt_ovf`.
  - Push and pop in the same cycle while full are both accepted; no drop.
- `min_ones` and `max_ones` update on every valid sample.
- `clear`, which has priority over a sample in the same cycle:
  - FSM → NORMAL, `run` = 0.
  - Event queue flushed.
  - `evt_ovf` = 0, `alarm_count` = 0, `min_ones` = all-ones, `max_ones` = 0.
  - `ts` is not cleared.
  - The coincident sample is discarded and does not advance `ts`.

## Timing
- Every output is registered.
- Reset values: `alarm` = 0, `alarm_kind` = 0, `evt_valid` = 0, `evt_data` = 0, `evt_ovf` = 0, `min_ones` = all-ones, `max_ones` = 0, `alarm_count` = 0, `ts` = 0, FSM = NORMAL.
- Latency: a sample valid at edge N is reflected in `alarm`, `alarm_kind`, min/max and `evt_valid` after edge N, i.e. 1 cycle.
- Handshake: a pop occurs when `evt_valid` && `evt_ready` at an edge. `evt_data` is stable while `evt_valid` = 1 and the entry is not popped.
- Asserting `rst_n` mid-run or mid-alarm returns all state to reset values immediately, with no clock needed.

## Structure
- Package `ones_mon_pkg` holds:
  - state enum `mon_state_e`: NORMAL, PENDING, ALARM, RECOVER.
  - kind enum `ones_kind_e`: NONE = 0, LOW = 1, HIGH = 2.
  - event struct type.
- Sub-module `mon_evt_fifo`: 2-deep valid/ready FIFO with a full flag. The parent drives the overflow logic.

## Test plan
Unless noted: `thr_lo` = 8, `thr_hi` = 24, TRIP_CNT = 4, CLEAR_CNT = 8, `evt_ready` = 1.
- Reset: pulse `rst_n` low → all outputs at reset values; `min_ones` = 255.
- Trip: samples 16, then 30, 30, 30, 30 (`ts` 0–4) → `alarm` = 1 one cycle after the 4th 30; `evt_data` = {1, HIGH, 4}; `alarm_count` = 1.
- Debounce: 30, 30, 30, 12, 30, 30, 30 → `alarm` stays 0 and no event is produced.
- Release: from ALARM, send 7×12, then 2, then 8×12 → `alarm` stays 1 until the last 12. Exactly one fall event {0, LOW, ts of the last 12}.
- Backpressure: `evt_ready` = 0 across 3 transitions → queue holds the first 2 events, `evt_ovf` = 1. Raise `evt_ready` → the 2 events pop in order.
- Clear/reset mid-op: `clear` coincident with a sample while in PENDING → NORMAL, `ts` unchanged, stats reset. A later async `rst_n` drop in ALARM → `alarm` falls without a clock edge.
